rwt_adc_channel_pack: RTL and testbench



---
 rtl/rwt_adc_channel_pack.sv | 125 ++++++++++++
 tb/tb_rwt_adc_channel_pack.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rwt_adc_channel_pack.sv
// rwt_adc_channel_pack: dense packer of enabled ADC channels into a FIFO-backed ready/valid stream.
// Optional drop counter enabled by defining RWT_ADC_PACK_DROP_CNT_EN.
module rwt_adc_channel_pack #(
  parameter int NUM_CHANNELS  = 4,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int ADDRESS_WIDTH = 9
) (
  input  logic                                 adc_clk,
  input  logic                                 adc_rst,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  input  logic [NUM_CHANNELS-1:0]              adc_enable,
  input  logic [NUM_CHANNELS-1:0]              adc_valid,
  output logic                                 adc_overflow,
`ifdef RWT_ADC_PACK_DROP_CNT_EN
  input  logic                                 drop_count_clr,
  output logic [31:0]                          drop_count,
`endif
  input  logic                                 m_user_ready,
  output logic                                 m_user_valid,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] m_user_data,
  output logic [NUM_CHANNELS-1:0]              m_user_enables,
  output logic [ADDRESS_WIDTH:0]               m_user_level
);
  localparam int NC = NUM_CHANNELS;
  localparam int SW = SAMPLE_WIDTH;
  localparam int DW = NC * SW;
  localparam int CW = $clog2(2 * NC + 1);
  localparam int LW = ADDRESS_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  logic [DW-1:0] s0_data;
  logic [NC-1:0] s0_mask, pmask;
  logic s0_beat, wr, push, pop_mem, full, unused_valid;
  logic [CW-1:0] fill, fill_n;
  logic [SW-1:0] comp [NC];
  logic [SW-1:0] acc [2*NC];
  logic [SW-1:0] nacc [2*NC];
  logic [SW-1:0] acc_n [2*NC];
  logic [DW-1:0] wdata;
  int below [NC];
  int n, f, tot;
  logic [DW+NC-1:0] mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wptr, rptr;
  logic [LW-1:0] level;
  assign unused_valid = ^adc_valid;
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      s0_beat <= 1'b0;
      s0_data <= '0;
      s0_mask <= '0;
    end else begin
      s0_beat <= adc_valid[0];
      if (adc_valid[0]) begin
        s0_data <= adc_data;
        s0_mask <= adc_enable;
      end
    end
  end
  // Compaction by rank: an enabled channel lands at the slot equal to the enabled channels below it.
  always_comb begin
    n = 0;
    for (int j = 0; j < NC; j++) begin
      below[j] = n;
      n = n + int'(s0_mask[j]);
    end
    for (int k = 0; k < NC; k++) begin
      comp[k] = '0;
      for (int j = 0; j < NC; j++) if (s0_mask[j] && below[j] == k) comp[k] = s0_data[j*SW +: SW];
    end
    f = (s0_mask == pmask) ? int'(fill) : 0;
    tot = f + n;
    wr = s0_beat && n != 0 && tot >= NC;
    for (int i = 0; i < 2 * NC; i++) begin
      nacc[i] = acc[i];
      for (int k = 0; k < NC; k++) if (k < n && i == f + k) nacc[i] = comp[k];
    end
    for (int i = 0; i < NC; i++) acc_n[i] = wr ? nacc[i+NC] : nacc[i];
    for (int i = NC; i < 2 * NC; i++) acc_n[i] = wr ? '0 : nacc[i];
    wdata = '0;
    for (int k = 0; k < NC; k++) wdata[k*SW +: SW] = nacc[k];
    fill_n = CW'(wr ? tot - NC : tot);
  end
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      fill <= '0;
      pmask <= '0;
      for (int i = 0; i < 2 * NC; i++) acc[i] <= '0;
    end else if (s0_beat && n != 0) begin
      fill <= fill_n;
      pmask <= s0_mask;
      for (int i = 0; i < 2 * NC; i++) acc[i] <= acc_n[i];
    end
  end
  // The output register only refills from storage, so a full array always drops, even on a pop.
  assign full = level == LW'(DEPTH);
  assign push = wr && !full;
  assign pop_mem = level != '0 && (!m_user_valid || m_user_ready);
  assign m_user_level = level;
  always_ff @(posedge adc_clk) if (push) mem[wptr] <= {s0_mask, wdata};
  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      m_user_valid <= 1'b0;
      m_user_data <= '0;
      m_user_enables <= '0;
      adc_overflow <= 1'b0;
    end else begin
      wptr <= push ? wptr + 1'b1 : wptr;
      rptr <= pop_mem ? rptr + 1'b1 : rptr;
      level <= level + LW'(push) - LW'(pop_mem);
      adc_overflow <= wr && full;
      if (pop_mem) begin
        m_user_valid <= 1'b1;
        {m_user_enables, m_user_data} <= mem[rptr];
      end else if (m_user_ready) m_user_valid <= 1'b0;
    end
  end
`ifdef RWT_ADC_PACK_DROP_CNT_EN
  always_ff @(posedge adc_clk) begin
    if (adc_rst || drop_count_clr) drop_count <= '0;
    else if (wr && full && drop_count != '1) drop_count <= drop_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rwt_adc_channel_pack.sv
// tb_rwt_adc_channel_pack: directed scoreboard bench for the ADC channel packer (4 ch, 4-word FIFO).
module tb_rwt_adc_channel_pack;
  logic clk, rst, ready, valid;
  logic [63:0] adc_data, data;
  logic [3:0] adc_enable, adc_valid, enables;
  logic overflow;
  logic [2:0] level;
`ifdef RWT_ADC_PACK_DROP_CNT_EN
  logic clr;
  logic [31:0] drop_count;
`endif
  logic [67:0] sb[$];
  int tests = 0, fails = 0;

  rwt_adc_channel_pack #(.NUM_CHANNELS(4), .SAMPLE_WIDTH(16), .ADDRESS_WIDTH(2)) dut (
    .adc_clk(clk), .adc_rst(rst), .adc_data(adc_data), .adc_enable(adc_enable),
    .adc_valid(adc_valid), .adc_overflow(overflow),
`ifdef RWT_ADC_PACK_DROP_CNT_EN
    .drop_count_clr(clr), .drop_count(drop_count),
`endif
    .m_user_ready(ready), .m_user_valid(valid), .m_user_data(data),
    .m_user_enables(enables), .m_user_level(level));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] m);
    adc_data = d;
    adc_enable = m;
    adc_valid = 4'hF;
    @(posedge clk);
    #1 adc_valid = 4'h0;
  endtask

  task automatic cyc(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL extra_word: observed %0h expected no word", data);
      end
      if (sb.size() != 0) begin
        logic [67:0] e;
        e = sb.pop_front();
        chk("word_data", data, e[63:0]);
        chk("word_enables", enables, e[67:64]);
      end
    end
  end

  initial begin
    rst = 1; ready = 0; adc_data = '0; adc_enable = '0; adc_valid = '0;
`ifdef RWT_ADC_PACK_DROP_CNT_EN
    clr = 0;
`endif
    cyc(2);
    chk("rst_valid", valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", data, 0);
    chk("rst_enables", enables, 0);
    rst = 0;
    // full mask, one word per beat, latency check on the first
    ready = 1;
    sb.push_back({4'hF, 64'h0003_0002_0001_0000});
    beat(64'h0003_0002_0001_0000, 4'hF);
    chk("lat_k", valid, 0);
    cyc(1);
    chk("lat_k1", valid, 0);
    cyc(1);
    chk("lat_k2", valid, 1);
    for (int i = 1; i < 4; i++) begin
      logic [15:0] b;
      b = 16'(i) << 8;
      sb.push_back({4'hF, b | 16'h3, b | 16'h2, b | 16'h1, b});
      beat({b | 16'h3, b | 16'h2, b | 16'h1, b}, 4'hF);
    end
    drain();
    // single channel; a beat without adc_valid[0] is ignored
    sb.push_back({4'h1, 64'h0003_0002_0001_0000});
    sb.push_back({4'h1, 64'h0007_0006_0005_0004});
    for (int i = 0; i < 8; i++) begin
      beat({16'hDEAD, 16'hDEAD, 16'hDEAD, 16'(i)}, 4'h1);
      if (i == 3) begin
        adc_data = {48'hDEAD_DEAD_DEAD, 16'h0BAD};
        adc_valid = 4'b1110;
        cyc(1);
        adc_valid = 4'h0;
      end
    end
    drain();
    // three of four channels: samples straddle word boundaries
    sb.push_back({4'h7, 64'h0100_0002_0001_0000});
    sb.push_back({4'h7, 64'h0201_0200_0102_0101});
    sb.push_back({4'h7, 64'h0302_0301_0300_0202});
    for (int b = 0; b < 4; b++)
      beat({16'hEEEE, 16'(b * 256 + 2), 16'(b * 256 + 1), 16'(b * 256)}, 4'h7);
    drain();
    // mask change discards a partial word
    beat(64'hDEAD_DEAD_DEAD_00A0, 4'h1);
    beat(64'hDEAD_DEAD_DEAD_00A1, 4'h1);
    sb.push_back({4'hF, 64'h5503_5502_5501_5500});
    beat(64'h5503_5502_5501_5500, 4'hF);
    drain();
    chk("mask_chg_overflow", overflow, 0);
    chk("mask_chg_level", level, 0);
    // fill to full with ready low; sixth word dropped
    ready = 0;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] b;
      b = 16'h4000 | (16'(i) << 8);
      if (i < 5) sb.push_back({4'hF, b | 16'h3, b | 16'h2, b | 16'h1, b});
      beat({b | 16'h3, b | 16'h2, b | 16'h1, b}, 4'hF);
    end
    chk("pre_drop_overflow", overflow, 0);
    cyc(1);
    chk("drop_overflow", overflow, 1);
    chk("full_level", level, 4);
    chk("full_valid", valid, 1);
    chk("hold_data", data, 64'h4003_4002_4001_4000);
    cyc(1);
    chk("drop_pulse_end", overflow, 0);
    chk("sat_level", level, 4);
`ifdef RWT_ADC_PACK_DROP_CNT_EN
    chk("drop_count", drop_count, 1);
    clr = 1;
    cyc(1);
    clr = 0;
    chk("drop_count_clr", drop_count, 0);
`endif
    ready = 1;
    drain();
    chk("drained_level", level, 0);
    // reset mid-stream with words held and a partial word pending
    ready = 0;
    for (int i = 0; i < 4; i++) beat({4{16'h6600 | 16'(i)}}, 4'hF);
    beat(64'hDEAD_DEAD_DEAD_0077, 4'h1);
    cyc(2);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_valid", valid, 1);
    rst = 1;
    cyc(1);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_overflow", overflow, 0);
`ifdef RWT_ADC_PACK_DROP_CNT_EN
    chk("mid_rst_drop_count", drop_count, 0);
`endif
    rst = 0;
    ready = 1;
    sb.push_back({4'h1, 64'h0063_0062_0061_0060});
    for (int i = 0; i < 4; i++) beat({48'hDEAD_DEAD_DEAD, 16'h0060 + 16'(i)}, 4'h1);
    drain();
    cyc(3);
    chk("end_overflow", overflow, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
